uart_cmd_decoder: RTL and testbench

- Bridges the UART byte stream to the shift-register controller.
- Assembles command frames from UART RX bytes, drives the controller's cmd_valid/cmd/data_in handshake, and waits for command completion.
- For read commands, captures the returned 42-bit word and streams it back to the UART transmitter as bytes.
- Sits between the UART receiver/transmitter and sreg_ctrl.

---
 rtl/uart_cmd_decoder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// UART RX byte frames -> sreg_ctrl cmd_valid/cmd_ready handshake; read data streamed back as TX bytes.
// cmd_valid rises one cycle after the last frame byte; tx_ready stalls TX per byte; CMD_CHECKSUM_EN adds XOR check bytes.
module uart_cmd_decoder #(
  parameter int         DATA_W   = 42,
  parameter int         N_BYTES  = 6,
  parameter int         TIMEOUT  = 1000,
  parameter logic [4:0] HDR_MARK = 5'b10101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_dout,
  input  logic              rx_vout,
  output logic              cmd_valid,
  output logic [2:0]        cmd,
  output logic [DATA_W-1:0] data_in,
  input  logic              cmd_ready,
  input  logic [DATA_W-1:0] data_out,
  output logic [7:0]        tx_din,
  output logic              tx_vin,
  input  logic              tx_ready,
  output logic              busy,
  output logic              frame_err
);
  localparam int CW = $clog2(N_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(N_BYTES - 1);
  localparam logic [TW-1:0] TOUT_MAX  = TW'(TIMEOUT);
`ifdef CMD_CHECKSUM_EN
  localparam logic [CW-1:0] CSUM_IDX  = CW'(N_BYTES);
`endif

  typedef enum logic [2:0] {
    IDLE,
    RX_PAY,
`ifdef CMD_CHECKSUM_EN
    RX_CSUM,
`endif
    ISSUE,
    WAIT_DONE,
    TX
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        tx_din_q, tx_din_d;
  logic              tx_vin_q, tx_vin_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic [CW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [TW-1:0]     tout_q, tout_d;
  logic              wait_first_q, wait_first_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  function automatic logic has_payload(input logic [2:0] c);
    return !(c == 3'b001 || c == 3'b010 || c == 3'b111);
  endfunction

  // Byte k of a word; bits beyond DATA_W read as zero.
  function automatic logic [7:0] word_byte(input logic [DATA_W-1:0] w, input logic [CW-1:0] k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i / 8 == int'(k)) b[i[2:0]] = w[i];
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w, input logic [CW-1:0] k,
                                                 input logic [7:0] b);
    logic [DATA_W-1:0] r;
    r = w;
    for (int i = 0; i < DATA_W; i++)
      if (i / 8 == int'(k)) r[i] = b[i[2:0]];
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    data_in_d    = data_in_q;
    rdata_d      = rdata_q;
    tx_din_d     = tx_din_q;
    tx_vin_d     = tx_vin_q;
    frame_err_d  = 1'b0;
    byte_cnt_d   = byte_cnt_q;
    tout_d       = tout_q;
    wait_first_d = 1'b0;
`ifdef CMD_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_vout) begin
          if (rx_dout[7:3] == HDR_MARK) begin
            cmd_d      = rx_dout[2:0];
            data_in_d  = '0;
            byte_cnt_d = '0;
            tout_d     = '0;
`ifdef CMD_CHECKSUM_EN
            csum_d     = rx_dout;
            state_d    = has_payload(rx_dout[2:0]) ? RX_PAY : RX_CSUM;
`else
            state_d    = has_payload(rx_dout[2:0]) ? RX_PAY : ISSUE;
`endif
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      RX_PAY: begin
        if (rx_vout) begin
          data_in_d = put_byte(data_in_q, byte_cnt_q, rx_dout);
          tout_d    = '0;
`ifdef CMD_CHECKSUM_EN
          csum_d    = csum_q ^ rx_dout;
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
`ifdef CMD_CHECKSUM_EN
            state_d    = RX_CSUM;
`else
            state_d    = ISSUE;
`endif
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tout_q == TOUT_MAX - 1'b1) begin
          // Partial data_in is left as-is; nothing is issued.
          frame_err_d = 1'b1;
          tout_d      = '0;
          byte_cnt_d  = '0;
          state_d     = IDLE;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
`ifdef CMD_CHECKSUM_EN
      RX_CSUM: begin
        if (rx_vout) begin
          tout_d = '0;
          if (rx_dout == csum_q) begin
            state_d = ISSUE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (tout_q == TOUT_MAX - 1'b1) begin
          frame_err_d = 1'b1;
          tout_d      = '0;
          state_d     = IDLE;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end
`endif
      ISSUE: begin
        if (rx_vout) frame_err_d = 1'b1;
        if (cmd_ready) begin
          wait_first_d = 1'b1;
          state_d      = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rx_vout) frame_err_d = 1'b1;
        // wait_first_q masks the ready that accompanied the latch cycle.
        if (!wait_first_q && cmd_ready) begin
          if (cmd_q == 3'b001 || cmd_q == 3'b111) begin
            rdata_d    = data_out;
            tx_din_d   = word_byte(data_out, '0);
            tx_vin_d   = 1'b1;
            byte_cnt_d = '0;
`ifdef CMD_CHECKSUM_EN
            csum_d     = '0;
`endif
            state_d    = TX;
          end else begin
            state_d = IDLE;
          end
        end
      end
      TX: begin
        if (rx_vout) frame_err_d = 1'b1;
        if (tx_vin_q && tx_ready) begin
`ifdef CMD_CHECKSUM_EN
          csum_d = csum_q ^ tx_din_q;
          if (byte_cnt_q == CSUM_IDX) begin
            tx_vin_d   = 1'b0;
            tx_din_d   = '0;
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else if (byte_cnt_q == LAST_BYTE) begin
            tx_din_d   = csum_q ^ tx_din_q;
            byte_cnt_d = CSUM_IDX;
          end else begin
            tx_din_d   = word_byte(rdata_q, byte_cnt_q + 1'b1);
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
`else
          if (byte_cnt_q == LAST_BYTE) begin
            tx_vin_d   = 1'b0;
            tx_din_d   = '0;
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            tx_din_d   = word_byte(rdata_q, byte_cnt_q + 1'b1);
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_valid_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      data_in_q    <= '0;
      rdata_q      <= '0;
      cmd_valid_q  <= 1'b0;
      tx_din_q     <= '0;
      tx_vin_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      byte_cnt_q   <= '0;
      tout_q       <= '0;
      wait_first_q <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      data_in_q    <= data_in_d;
      rdata_q      <= rdata_d;
      cmd_valid_q  <= cmd_valid_d;
      tx_din_q     <= tx_din_d;
      tx_vin_q     <= tx_vin_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      byte_cnt_q   <= byte_cnt_d;
      tout_q       <= tout_d;
      wait_first_q <= wait_first_d;
`ifdef CMD_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign data_in   = data_in_q;
  assign tx_din    = tx_din_q;
  assign tx_vin    = tx_vin_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: frame vector table plus hand sequences; scoreboard queues checked by controller and TX sink models.
`timescale 1ns/1ps
module tb_uart_cmd_decoder;
  localparam int DATA_W  = 42;
  localparam int N_BYTES = 6;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_dout;
  logic              rx_vout;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [DATA_W-1:0] data_in;
  logic              cmd_ready;
  logic [DATA_W-1:0] data_out;
  logic [7:0]        tx_din;
  logic              tx_vin;
  logic              tx_ready;
  logic              busy;
  logic              frame_err;

  uart_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .rx_dout(rx_dout), .rx_vout(rx_vout),
    .cmd_valid(cmd_valid), .cmd(cmd), .data_in(data_in), .cmd_ready(cmd_ready),
    .data_out(data_out), .tx_din(tx_din), .tx_vin(tx_vin), .tx_ready(tx_ready),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        hdr;
    logic [47:0]       pay;
    logic [DATA_W-1:0] dout;
    logic [2:0]        exp_cmd;
    logic [DATA_W-1:0] exp_din;
  } vec_t;

  typedef struct {
    logic [2:0]        c;
    logic [DATA_W-1:0] d;
  } exp_cmd_t;

  exp_cmd_t          exp_cmd_q[$];
  logic [DATA_W-1:0] ctl_rd_q[$];
  logic [7:0]        exp_tx_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int err_cnt = 0;
  int tx_acc = 0;
  int ctl_st = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic has_pay(input logic [2:0] c);
    return !(c == 3'd1 || c == 3'd2 || c == 3'd7);
  endfunction

  function automatic void push_tx(input logic [DATA_W-1:0] d);
    logic [47:0] w;
    logic [7:0]  x;
    w = 48'(d);
    x = '0;
    for (int i = 0; i < N_BYTES; i++) begin
      exp_tx_q.push_back(w[8*i +: 8]);
      x ^= w[8*i +: 8];
    end
`ifdef CMD_CHECKSUM_EN
    exp_tx_q.push_back(x);
`endif
  endfunction

  task automatic push_exp(input vec_t v);
    exp_cmd_t e;
    e.c = v.exp_cmd;
    e.d = v.exp_din;
    exp_cmd_q.push_back(e);
    ctl_rd_q.push_back(v.dout);
    if (v.hdr[2:0] == 3'd1 || v.hdr[2:0] == 3'd7) push_tx(v.dout);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic send_byte(input logic [7:0] b);
    rx_dout = b;
    rx_vout = 1'b1;
    @(negedge clk);
    rx_vout = 1'b0;
  endtask

  task automatic send_frame(input vec_t v, input int gap, input int csum_byte);
`ifdef CMD_CHECKSUM_EN
    logic [7:0] x;
    x = v.hdr;
    if (has_pay(v.hdr[2:0]))
      for (int i = 0; i < N_BYTES; i++) x ^= v.pay[8*i +: 8];
`endif
    send_byte(v.hdr);
    if (has_pay(v.hdr[2:0]))
      for (int i = 0; i < N_BYTES; i++) begin
        repeat (gap) @(negedge clk);
        send_byte(v.pay[8*i +: 8]);
      end
`ifdef CMD_CHECKSUM_EN
    send_byte(csum_byte < 0 ? x : csum_byte[7:0]);
`endif
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (n < 5000 && !(busy == 1'b0 && ctl_st == 0 && exp_tx_q.size() == 0 && exp_cmd_q.size() == 0)) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_complete"}, 64'(n < 5000), 64'd1);
    check({nm, "_tx_vin_low"}, 64'(tx_vin), 64'd0);
  endtask

  // Controller model: latches after a short delay, signals done later, returns read data.
  initial begin : ctl
    int wait_c;
    exp_cmd_t e;
    cmd_ready = 1'b0;
    data_out  = '0;
    wait_c    = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ctl_st = 0;
        cmd_ready = 1'b0;
        continue;
      end
      case (ctl_st)
        0: begin
          cmd_ready = 1'b0;
          if (cmd_valid) begin
            ctl_st = 1;
            wait_c = 2;
          end
        end
        1: begin
          check("cmd_valid_held", 64'(cmd_valid), 64'd1);
          if (wait_c == 0) begin
            cmd_ready = 1'b1;
            if (exp_cmd_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL cmd_unexpected: got cmd %0d expected no command", cmd);
            end else begin
              e = exp_cmd_q.pop_front();
              check("cmd", 64'(cmd), 64'(e.c));
              check("data_in", 64'(data_in), 64'(e.d));
            end
            ctl_st = 2;
            wait_c = 3;
          end else begin
            wait_c--;
          end
        end
        2: begin
          if (wait_c == 3) check("cmd_valid_drop", 64'(cmd_valid), 64'd0);
          cmd_ready = 1'b0;
          if (wait_c == 0) begin
            cmd_ready = 1'b1;
            data_out  = (ctl_rd_q.size() != 0) ? ctl_rd_q.pop_front() : '0;
            ctl_st    = 3;
          end else begin
            wait_c--;
          end
        end
        default: begin
          cmd_ready = 1'b0;
          data_out  = 42'h155_5555_5555;
          ctl_st    = 0;
        end
      endcase
    end
  end

  // TX sink: holds tx_ready low for 3 cycles per byte, then accepts.
  initial begin : sink
    int stall;
    tx_ready = 1'b0;
    stall = 3;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tx_ready = 1'b0;
        stall = 3;
        continue;
      end
      if (tx_vin) begin
        if (exp_tx_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected: got byte %0h expected none", tx_din);
          tx_ready = 1'b1;
        end else if (stall > 0) begin
          check("tx_hold", 64'(tx_din), 64'(exp_tx_q[0]));
          tx_ready = 1'b0;
          stall--;
        end else begin
          check("tx_byte", 64'(tx_din), 64'(exp_tx_q.pop_front()));
          tx_ready = 1'b1;
          stall = 3;
          tx_acc++;
        end
      end else begin
        tx_ready = 1'b0;
      end
    end
  end

  initial begin : errmon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) begin
        err_cnt++;
        check("frame_err_width", 64'(prev), 64'd0);
      end
      prev = frame_err;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t       vecs[8];
    logic [7:0] bad[3];
    int         base_err;
    int         base_acc;
    int         n;
    rx_dout = '0;
    rx_vout = 1'b0;
    rst_n   = 1'b0;
    vecs[0] = '{8'hA8, 48'h026B4B5F692B, 42'h155_5555_5555, 3'd0, 42'h26B4B5F692B};
    vecs[1] = '{8'hAF, 48'h0,            42'h3FF_0000_1234, 3'd7, 42'h0};
    vecs[2] = '{8'hAA, 48'h0,            42'h123_4567_8ABC, 3'd2, 42'h0};
    vecs[3] = '{8'hAB, 48'hFFFFFFFFFFFF, 42'h155_5555_5555, 3'd3, 42'h3FF_FFFF_FFFF};
    vecs[4] = '{8'hA9, 48'h0,            42'h2AA_5555_00FF, 3'd1, 42'h0};
    vecs[5] = '{8'hAC, 48'hFC0504030201, 42'h155_5555_5555, 3'd4, 42'h005_0403_0201};
    vecs[6] = '{8'hAD, 48'hBA9876543210, 42'h155_5555_5555, 3'd5, 42'h298_7654_3210};
    vecs[7] = '{8'hAE, 48'h010000000000, 42'h155_5555_5555, 3'd6, 42'h100_0000_0000};
    bad[0] = 8'h28;
    bad[1] = 8'hF8;
    bad[2] = 8'hA0;

    repeat (3) @(negedge clk);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd", 64'(cmd), 64'd0);
    check("rst_data_in", 64'(data_in), 64'd0);
    check("rst_tx_din", 64'(tx_din), 64'd0);
    check("rst_tx_vin", 64'(tx_vin), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      base_err = err_cnt;
      push_exp(vecs[i]);
      send_frame(vecs[i], 0, -1);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_no_err", i), 64'(err_cnt - base_err), 64'd0);
    end

    for (int i = 0; i < 3; i++) begin
      base_err = err_cnt;
      send_byte(bad[i]);
      repeat (3) @(negedge clk);
      check($sformatf("badhdr%0d_err", i), 64'(err_cnt - base_err), 64'd1);
      check($sformatf("badhdr%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("badhdr%0d_cmd_valid", i), 64'(cmd_valid), 64'd0);
    end

    base_err = err_cnt;
    send_byte(8'hA8);
    for (int i = 0; i < 3; i++) send_byte(vecs[0].pay[8*i +: 8]);
    n = 0;
    while (err_cnt == base_err && n < TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    check("tout_err", 64'(err_cnt - base_err), 64'd1);
    check("tout_delay", 64'(n >= TIMEOUT - 2 && n <= TIMEOUT + 2), 64'd1);
    check("tout_busy", 64'(busy), 64'd0);
    push_exp(vecs[0]);
    send_frame(vecs[0], 0, -1);
    wait_idle("after_tout");
    check("after_tout_err", 64'(err_cnt - base_err), 64'd1);

    base_err = err_cnt;
    push_exp(vecs[6]);
    send_frame(vecs[6], TIMEOUT - 10, -1);
    wait_idle("slow_bytes");
    check("slow_bytes_no_err", 64'(err_cnt - base_err), 64'd0);

    base_err = err_cnt;
    push_exp(vecs[1]);
    send_frame(vecs[1], 0, -1);
    n = 0;
    while (ctl_st != 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ovr_reach_wait", 64'(n < 200), 64'd1);
    @(negedge clk);
    send_byte(8'hA8);
    wait_idle("ovr");
    check("ovr_err", 64'(err_cnt - base_err), 64'd1);

    base_acc = tx_acc;
    push_exp(vecs[4]);
    send_frame(vecs[4], 0, -1);
    n = 0;
    while (tx_acc - base_acc < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rsttx_reach", 64'(n < 500), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rsttx_tx_vin", 64'(tx_vin), 64'd0);
    check("rsttx_busy", 64'(busy), 64'd0);
    check("rsttx_tx_din", 64'(tx_din), 64'd0);
    check("rsttx_cmd_valid", 64'(cmd_valid), 64'd0);
    exp_tx_q.delete();
    exp_cmd_q.delete();
    ctl_rd_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rsttx_still_idle", 64'(busy), 64'd0);
    push_exp(vecs[1]);
    send_frame(vecs[1], 0, -1);
    wait_idle("after_rst");

`ifdef CMD_CHECKSUM_EN
    base_err = err_cnt;
    send_frame(vecs[0], 0, 0);
    repeat (3) @(negedge clk);
    check("csum_bad_err", 64'(err_cnt - base_err), 64'd1);
    check("csum_bad_busy", 64'(busy), 64'd0);
    check("csum_bad_cmd_valid", 64'(cmd_valid), 64'd0);
    push_exp(vecs[0]);
    send_frame(vecs[0], 0, -1);
    wait_idle("csum_good");
    check("csum_good_err", 64'(err_cnt - base_err), 64'd1);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
